// File: rtl/ball_motion.sv
// Per-frame ball kinematics: launch, gravity, wall bounces, flipper kick and drain.
// Advances once per video frame and drives the blob renderer's position/enable inputs.
module ball_motion #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BLOB_SIZE    = 4,
    parameter int START_X      = 600,
    parameter int START_Y      = 400,
    parameter int LAUNCH_VX    = -3,
    parameter int LAUNCH_VY    = -12,
    parameter int VMAX         = 15,
    parameter int GRAVITY_DIV  = 4,
    parameter int KICK_Y       = 440,
    parameter int UPDATE_LINE  = 480,
    parameter int DRAIN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       launch,
    input  logic       kick,
    output logic [9:0] x_loc,
    output logic [9:0] y_loc,
    output logic       enable,
    output logic       drained,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        ROLL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
    localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BLOB_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(SCREEN_H - BLOB_SIZE);
    localparam logic signed [7:0]  V_HI    = 8'(VMAX);
    localparam logic signed [7:0]  V_LO    = 8'(-VMAX);
    localparam logic [GW-1:0]      G_LAST  = GW'(GRAVITY_DIV - 1);
    localparam logic [5:0]         D_LAST  = 6'(DRAIN_FRAMES - 1);

    state_t            st, st_nxt;
    logic [9:0]        x, x_nxt, y, y_nxt;
    logic signed [5:0] vx, vx_nxt, vy, vy_nxt;
    logic [GW-1:0]     gcnt, gcnt_nxt;
    logic [5:0]        dcnt, dcnt_nxt;
    logic              kick_pend, kick_pend_nxt;
    logic              en, en_nxt, drn, drn_nxt;
    logic              cond, cond_d, tick, kick_hit;
    logic signed [10:0] nx, ny;
    logic signed [7:0]  vy_b, vy_g;

    // Edge-detect the update point so a held hcount still yields one tick per frame.
    assign cond     = (hcount == 10'd0) && (vcount == 10'(UPDATE_LINE));
    assign tick     = cond && !cond_d;
    assign nx       = $signed({1'b0, x}) + 11'(vx);
    assign ny       = $signed({1'b0, y}) + 11'(vy);
    assign kick_hit = kick_pend && (y >= 10'(KICK_Y)) && (vy > 6'sd0);

    always_comb begin
        // NOTE: every next-value gets a default first so no path leaves it unassigned (no latches).
        st_nxt        = st;
        x_nxt         = x;
        y_nxt         = y;
        vx_nxt        = vx;
        vy_nxt        = vy;
        gcnt_nxt      = gcnt;
        dcnt_nxt      = dcnt;
        en_nxt        = en;
        drn_nxt       = 1'b0;
        vy_b          = '0;
        vy_g          = '0;
        kick_pend_nxt = tick ? kick : (kick_pend | kick);

        if (tick) begin
            unique case (st)
                PARK: begin
                    if (launch) begin
                        st_nxt   = ROLL;
                        vx_nxt   = 6'(LAUNCH_VX);
                        vy_nxt   = 6'(LAUNCH_VY);
                        gcnt_nxt = '0;
                    end
                end
                ROLL: begin
                    if (nx[10]) begin
                        x_nxt  = '0;
                        vx_nxt = -vx;
                    end else if (nx > X_MAX) begin
                        x_nxt  = 10'(X_MAX);
                        vx_nxt = -vx;
                    end else begin
                        x_nxt = nx[9:0];
                    end

                    if (ny[10]) begin
                        y_nxt = '0;
                        vy_b  = -8'(vy);
                    end else begin
                        y_nxt = ny[9:0];
                        vy_b  = 8'(vy);
                    end

                    if (gcnt == G_LAST) begin
                        vy_g     = vy_b + 8'sd1;
                        gcnt_nxt = '0;
                    end else begin
                        vy_g     = vy_b;
                        gcnt_nxt = gcnt + GW'(1);
                    end

                    if (vy_g > V_HI)      vy_nxt = 6'(V_HI);
                    else if (vy_g < V_LO) vy_nxt = 6'(V_LO);
                    else                  vy_nxt = vy_g[5:0];

                    // Kick decision uses pre-update y/vy; position above already used old vy.
                    if (kick_hit) vy_nxt = 6'(LAUNCH_VY);

                    if (ny > Y_MAX) begin
                        st_nxt   = DRAIN;
                        y_nxt    = 10'(Y_MAX);
                        vx_nxt   = '0;
                        vy_nxt   = '0;
                        dcnt_nxt = '0;
                        en_nxt   = 1'b0;
                        drn_nxt  = 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcnt == D_LAST) begin
                        st_nxt   = PARK;
                        x_nxt    = 10'(START_X);
                        y_nxt    = 10'(START_Y);
                        en_nxt   = 1'b1;
                        dcnt_nxt = '0;
                    end else begin
                        dcnt_nxt = dcnt + 6'd1;
                    end
                end
                default: st_nxt = PARK;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= PARK;
            x         <= 10'(START_X);
            y         <= 10'(START_Y);
            vx        <= '0;
            vy        <= '0;
            gcnt      <= '0;
            dcnt      <= '0;
            kick_pend <= 1'b0;
            en        <= 1'b1;
            drn       <= 1'b0;
            cond_d    <= 1'b0;
        end else begin
            st        <= st_nxt;
            x         <= x_nxt;
            y         <= y_nxt;
            vx        <= vx_nxt;
            vy        <= vy_nxt;
            gcnt      <= gcnt_nxt;
            dcnt      <= dcnt_nxt;
            kick_pend <= kick_pend_nxt;
            en        <= en_nxt;
            drn       <= drn_nxt;
            cond_d    <= cond;
        end
    end

    assign x_loc   = x;
    assign y_loc   = y;
    assign enable  = en;
    assign drained = drn;
    assign state   = st;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: two instances (stock and a small playfield) checked every frame
// against an integer kinematics model, plus hand-derived trajectory points.
module tb_ball_motion;

    typedef struct {
        int st, x, y, vx, vy, gcnt, dcnt;
        bit pend;
    } mstate_t;

    typedef struct {
        int w, h, b, sx, sy, lvx, lvy, vmax, gdiv, ky, dframes;
    } mparam_t;

    localparam int UPD = 480;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [9:0]       hcount, vcount;
    logic             launch, kick;
    logic [1:0][9:0]  xl, yl;
    logic [1:0]       en, drn;
    logic [1:0][1:0]  st;

    mparam_t p [2];
    mstate_t m [2];
    int vecs = 0;
    int miss = 0;

    ball_motion dut0 (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .launch(launch), .kick(kick), .x_loc(xl[0]), .y_loc(yl[0]),
        .enable(en[0]), .drained(drn[0]), .state(st[0])
    );

    ball_motion #(
        .SCREEN_W(64), .SCREEN_H(96), .BLOB_SIZE(4), .START_X(50), .START_Y(60),
        .LAUNCH_VX(5), .LAUNCH_VY(-8), .VMAX(8), .GRAVITY_DIV(2), .KICK_Y(70),
        .UPDATE_LINE(UPD), .DRAIN_FRAMES(5)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .launch(launch), .kick(kick), .x_loc(xl[1]), .y_loc(yl[1]),
        .enable(en[1]), .drained(drn[1]), .state(st[1])
    );

    function automatic mstate_t park_state(input mparam_t q);
        mstate_t r;
        r = '{st: 0, x: q.sx, y: q.sy, vx: 0, vy: 0, gcnt: 0, dcnt: 0, pend: 1'b0};
        return r;
    endfunction

    // One frame of the game rules, in plain integer arithmetic.
    function automatic mstate_t step(input mstate_t s, input mparam_t q, input bit l, output bit dr);
        mstate_t r;
        int nx, ny, v;
        r  = s;
        dr = 1'b0;
        if (s.st == 0) begin
            if (l) begin
                r.st = 1; r.vx = q.lvx; r.vy = q.lvy; r.gcnt = 0;
            end
        end else if (s.st == 1) begin
            nx = s.x + s.vx;
            ny = s.y + s.vy;
            if (nx < 0)                 begin r.x = 0;          r.vx = -s.vx; end
            else if (nx > q.w - q.b)    begin r.x = q.w - q.b;  r.vx = -s.vx; end
            else                        r.x = nx;
            v = s.vy;
            if (ny < 0) begin r.y = 0; v = -s.vy; end
            else        r.y = ny;
            if (s.gcnt == q.gdiv - 1) begin v = v + 1; r.gcnt = 0; end
            else                      r.gcnt = s.gcnt + 1;
            if (v > q.vmax)  v = q.vmax;
            if (v < -q.vmax) v = -q.vmax;
            r.vy = v;
            if (s.pend && s.y >= q.ky && s.vy > 0) r.vy = q.lvy;
            if (ny > q.h - q.b) begin
                r.st = 2; r.y = q.h - q.b; r.vx = 0; r.vy = 0; r.dcnt = 0; dr = 1'b1;
            end
        end else begin
            if (s.dcnt == q.dframes - 1) begin
                r.st = 0; r.x = q.sx; r.y = q.sy; r.dcnt = 0;
            end else begin
                r.dcnt = s.dcnt + 1;
            end
        end
        return r;
    endfunction

    // Drive one frame (optional mid-frame kick, kick on the tick cycle, update point held
    // for 'hold' clocks) and compare both instances right after the tick and at frame end.
    task automatic apply_frame(input bit l, input bit km, input bit kt, input int hold);
        bit dr [2];
        launch = l;
        hcount = 10'd3; vcount = 10'd100; kick = km;
        @(negedge clk);
        kick = 1'b0;
        @(negedge clk);
        hcount = 10'd0; vcount = 10'(UPD); kick = kt;
        @(negedge clk);
        kick = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (km) m[i].pend = 1'b1;
            m[i] = step(m[i], p[i], l, dr[i]);
            m[i].pend = kt;
            vecs++;
            if (xl[i] !== 10'(m[i].x)) begin
                miss++; $display("FAIL x_loc inst%0d: got %0d expected %0d", i, xl[i], m[i].x);
            end
            vecs++;
            if (yl[i] !== 10'(m[i].y)) begin
                miss++; $display("FAIL y_loc inst%0d: got %0d expected %0d", i, yl[i], m[i].y);
            end
            vecs++;
            if (st[i] !== 2'(m[i].st)) begin
                miss++; $display("FAIL state inst%0d: got %0d expected %0d", i, st[i], m[i].st);
            end
            vecs++;
            if (en[i] !== (m[i].st != 2)) begin
                miss++; $display("FAIL enable inst%0d: got %0b expected %0b", i, en[i], m[i].st != 2);
            end
            vecs++;
            if (drn[i] !== dr[i]) begin
                miss++; $display("FAIL drained inst%0d: got %0b expected %0b", i, drn[i], dr[i]);
            end
        end
        for (int c = 1; c < hold; c++) @(negedge clk);
        hcount = 10'd1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            vecs++;
            if (xl[i] !== 10'(m[i].x) || yl[i] !== 10'(m[i].y)) begin
                miss++;
                $display("FAIL frame_hold inst%0d: got (%0d,%0d) expected (%0d,%0d)", i, xl[i], yl[i], m[i].x, m[i].y);
            end
            vecs++;
            if (drn[i] !== 1'b0) begin
                miss++; $display("FAIL drained_width inst%0d: got %0b expected 0", i, drn[i]);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; hcount = 10'd3; vcount = 10'd100; launch = 1'b0; kick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) m[i] = park_state(p[i]);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            vecs++;
            if (xl[i] !== 10'(p[i].sx) || yl[i] !== 10'(p[i].sy) || en[i] !== 1'b1 ||
                st[i] !== 2'd0 || drn[i] !== 1'b0) begin
                miss++;
                $display("FAIL reset_state inst%0d: got x=%0d y=%0d en=%0b st=%0d dr=%0b expected x=%0d y=%0d en=1 st=0 dr=0",
                         i, xl[i], yl[i], en[i], st[i], drn[i], p[i].sx, p[i].sy);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) m[i] = park_state(p[i]);
        apply_frame(0, 0, 0, 1);
        apply_frame(0, 1, 0, 2);
        apply_frame(0, 0, 1, 1);
    endtask

    task automatic test_launch();
        int ex [5] = '{597, 594, 591, 588, 585};
        int ey [5] = '{388, 376, 364, 352, 341};
        do_reset();
        apply_frame(1, 0, 0, 1);
        vecs++;
        if (xl[0] !== 10'd600 || yl[0] !== 10'd400 || st[0] !== 2'd1) begin
            miss++; $display("FAIL launch_tick: got (%0d,%0d) st=%0d expected (600,400) st=1", xl[0], yl[0], st[0]);
        end
        for (int k = 0; k < 5; k++) begin
            apply_frame(0, 0, 0, 1);
            vecs++;
            if (xl[0] !== 10'(ex[k]) || yl[0] !== 10'(ey[k])) begin
                miss++;
                $display("FAIL launch_traj tick%0d: got (%0d,%0d) expected (%0d,%0d)", k + 1, xl[0], yl[0], ex[k], ey[k]);
            end
        end
    endtask

    task automatic test_tick_unique();
        apply_frame(0, 0, 0, 4);
        vecs++;
        if (xl[0] !== 10'd582 || yl[0] !== 10'd330) begin
            miss++; $display("FAIL tick_unique: got (%0d,%0d) expected (582,330)", xl[0], yl[0]);
        end
    endtask

    // Kick at y=439 (< KICK_Y) must be discarded at that tick, so the ball drains.
    task automatic test_kick_miss();
        for (int f = 0; f < 300 && !(m[0].st == 1 && m[0].y == 439); f++) apply_frame(0, 0, 0, 1);
        vecs++;
        if (!(m[0].st == 1 && m[0].y == 439)) begin
            miss++; $display("FAIL kick_miss_setup: got y=%0d expected 439", m[0].y);
        end
        apply_frame(0, 1, 0, 1);
        vecs++;
        if (yl[0] !== 10'd452) begin
            miss++; $display("FAIL kick_miss_y1: got %0d expected 452", yl[0]);
        end
        apply_frame(0, 0, 0, 1);
        vecs++;
        if (yl[0] !== 10'd466) begin
            miss++; $display("FAIL kick_miss_y2: got %0d expected 466", yl[0]);
        end
    endtask

    task automatic test_drain();
        apply_frame(1, 0, 0, 1);
        vecs++;
        if (st[0] !== 2'd2 || yl[0] !== 10'd476 || en[0] !== 1'b0) begin
            miss++; $display("FAIL drain_entry: got st=%0d y=%0d en=%0b expected st=2 y=476 en=0", st[0], yl[0], en[0]);
        end
        for (int k = 1; k <= 60; k++) begin
            apply_frame(1, 0, 0, 1);
            if (k < 60) begin
                vecs++;
                if (st[0] !== 2'd2) begin
                    miss++; $display("FAIL drain_hold tick%0d: got st=%0d expected 2", k, st[0]);
                end
            end else begin
                vecs++;
                if (st[0] !== 2'd0 || xl[0] !== 10'd600 || yl[0] !== 10'd400 || en[0] !== 1'b1) begin
                    miss++;
                    $display("FAIL drain_exit: got st=%0d (%0d,%0d) en=%0b expected st=0 (600,400) en=1", st[0], xl[0], yl[0], en[0]);
                end
            end
        end
    endtask

    task automatic test_kick();
        do_reset();
        apply_frame(1, 0, 0, 1);
        for (int f = 0; f < 300 && !(m[0].st == 1 && m[0].y == 452); f++) apply_frame(0, 0, 0, 1);
        vecs++;
        if (!(m[0].st == 1 && m[0].y == 452)) begin
            miss++; $display("FAIL kick_setup: got y=%0d expected 452", m[0].y);
        end
        apply_frame(0, 1, 0, 1);
        vecs++;
        if (yl[0] !== 10'd466) begin
            miss++; $display("FAIL kick_y1: got %0d expected 466", yl[0]);
        end
        apply_frame(0, 0, 0, 1);
        vecs++;
        if (yl[0] !== 10'd454) begin
            miss++; $display("FAIL kick_y2: got %0d expected 454", yl[0]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        apply_frame(1, 0, 0, 1);
        for (int f = 0; f < 8; f++) apply_frame(0, $urandom_range(0, 1), 0, 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            vecs++;
            if (xl[i] !== 10'(p[i].sx) || yl[i] !== 10'(p[i].sy) || en[i] !== 1'b1 || st[i] !== 2'd0) begin
                miss++;
                $display("FAIL async_reset inst%0d: got (%0d,%0d) en=%0b st=%0d expected (%0d,%0d) en=1 st=0",
                         i, xl[i], yl[i], en[i], st[i], p[i].sx, p[i].sy);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) m[i] = park_state(p[i]);
        for (int f = 0; f < 3; f++) apply_frame(0, 1, 0, 1);
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 1500; f++) begin
            apply_frame($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 5) == 0, int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        p[0] = '{640, 480, 4, 600, 400, -3, -12, 15, 4, 440, 60};
        p[1] = '{64, 96, 4, 50, 60, 5, -8, 8, 2, 70, 5};
        reset_n = 1'b0; hcount = 10'd3; vcount = 10'd100; launch = 1'b0; kick = 1'b0;
        test_reset();
        test_launch();
        test_tick_unique();
        test_kick_miss();
        test_drain();
        test_kick();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
